// File: rtl/precompute_pkg.sv
// Shared opcode encoding and helpers for the precompute execution pipe.
package precompute_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_AND  = 4'h1,
        OP_NOT  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_ADD  = 4'h5,
        OP_SUB  = 4'h6,
        OP_MOV0 = 4'h7,
        OP_MOV1 = 4'h8,
        OP_MOVI = 4'h9
    } opcode_t;

    // One candidate-result slot per defined opcode (slot 0 belongs to NOP).
    localparam int N_OPS = 10;

    // NOP and every undefined encoding (4'hA..4'hF) leave the register file alone.
    function automatic logic op_writes(input opcode_t op);
        return (op != OP_NOP) && (op <= OP_MOVI);
    endfunction

endpackage

// File: rtl/precompute_fifo.sv
// Small synchronous FIFO with combinational head read; full blocks pushes even when popping.
module precompute_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_reg == CNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign count    = count_reg;
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign pop_data = mem[rd_ptr_reg];

    // Storage array: written on accepted pushes, no reset needed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
            else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/precompute_exe_pipe.sv
// FIFO -> R (pop + regfile read) -> X (all candidate results) -> W (late select + writeback).
// Bypass from W into both R and X removes every data hazard, so the pipe never stalls on them.
module precompute_exe_pipe
    import precompute_pkg::*;
#(
    parameter  int W          = 32,
    parameter  int N_REGS     = 32,
    parameter  int FIFO_DEPTH = 4,
    localparam int RA_W       = $clog2(N_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_vld,
    input  logic [3:0]      in_op,
    input  logic [RA_W-1:0] in_wa,
    input  logic [RA_W-1:0] in_ra0,
    input  logic [RA_W-1:0] in_ra1,
    input  logic [W-1:0]    in_imm,
    output logic            in_rdy,
    input  logic            hold,
    output logic            wb_vld,
    output logic [RA_W-1:0] wb_wa,
    output logic [W-1:0]    wb_data,
    output logic            busy
);

    typedef struct packed {
        logic [3:0]      op;
        logic [RA_W-1:0] wa;
        logic [RA_W-1:0] ra0;
        logic [RA_W-1:0] ra1;
        logic [W-1:0]    imm;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    // FIFO / R stage
    entry_t           in_entry;
    entry_t           r_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             r_pop;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;

    // X stage
    logic             x_vld_reg;
    logic [3:0]       x_op_reg;
    logic [RA_W-1:0]  x_wa_reg;
    logic [RA_W-1:0]  x_ra0_reg;
    logic [RA_W-1:0]  x_ra1_reg;
    logic [W-1:0]     x_a_reg;
    logic [W-1:0]     x_b_reg;
    logic [W-1:0]     x_imm_reg;
    logic [W-1:0]     x_a;
    logic [W-1:0]     x_b;
    logic [W-1:0]     x_cand [N_OPS];

    // W stage
    logic             w_vld_reg;
    logic [3:0]       w_op_reg;
    logic [RA_W-1:0]  w_wa_reg;
    logic [W-1:0]     w_cand_reg [N_OPS];
    logic [W-1:0]     w_result;
    logic             w_writes;

    logic [W-1:0]     regs [N_REGS];

    assign in_entry = '{op: in_op, wa: in_wa, ra0: in_ra0, ra1: in_ra1, imm: in_imm};

    precompute_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_vld),
        .push_data (in_entry),
        .pop       (r_pop),
        .pop_data  (r_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign in_rdy = !fifo_full;
    assign r_pop  = !fifo_empty && !hold;

    // Late select: undefined opcodes fall out as zero and never write.
    assign w_result = (w_op_reg <= OP_MOVI) ? w_cand_reg[w_op_reg] : '0;
    assign w_writes = w_vld_reg && op_writes(opcode_t'(w_op_reg));

    // R-stage read; W holds the op two ahead, whose write has not landed yet.
    always_comb begin
        r_a = regs[r_entry.ra0];
        r_b = regs[r_entry.ra1];
        if (w_writes && (r_entry.ra0 == w_wa_reg)) r_a = w_result;
        if (w_writes && (r_entry.ra1 == w_wa_reg)) r_b = w_result;
    end

    // X-stage operand fix-up for the immediately preceding op; beats the R-stage capture.
    always_comb begin
        x_a = x_a_reg;
        x_b = x_b_reg;
        if (w_writes && (x_ra0_reg == w_wa_reg)) x_a = w_result;
        if (w_writes && (x_ra1_reg == w_wa_reg)) x_b = w_result;
    end

    // Every candidate is computed in parallel; the opcode only chooses among them in W.
    always_comb begin
        for (int i = 0; i < N_OPS; i++) x_cand[i] = '0;
        x_cand[OP_AND]  = x_a & x_b;
        x_cand[OP_NOT]  = ~x_a;
        x_cand[OP_OR]   = x_a | x_b;
        x_cand[OP_XOR]  = x_a ^ x_b;
        x_cand[OP_ADD]  = x_a + x_b;
        x_cand[OP_SUB]  = x_a - x_b;
        x_cand[OP_MOV0] = x_a;
        x_cand[OP_MOV1] = x_b;
        x_cand[OP_MOVI] = x_imm_reg;
    end

    // R -> X pipeline register; a bubble enters whenever nothing is popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_vld_reg <= 1'b0;
            x_op_reg  <= OP_NOP;
            x_wa_reg  <= '0;
            x_ra0_reg <= '0;
            x_ra1_reg <= '0;
            x_a_reg   <= '0;
            x_b_reg   <= '0;
            x_imm_reg <= '0;
        end else begin
            x_vld_reg <= r_pop;
            x_op_reg  <= r_entry.op;
            x_wa_reg  <= r_entry.wa;
            x_ra0_reg <= r_entry.ra0;
            x_ra1_reg <= r_entry.ra1;
            x_a_reg   <= r_a;
            x_b_reg   <= r_b;
            x_imm_reg <= r_entry.imm;
        end
    end

    // X -> W pipeline register carrying all candidates.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_vld_reg <= 1'b0;
            w_op_reg  <= OP_NOP;
            w_wa_reg  <= '0;
            for (int i = 0; i < N_OPS; i++) w_cand_reg[i] <= '0;
        end else begin
            w_vld_reg  <= x_vld_reg;
            w_op_reg   <= x_op_reg;
            w_wa_reg   <= x_wa_reg;
            w_cand_reg <= x_cand;
        end
    end

    // Register file: cleared on reset, written from W.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
        end else if (w_writes) begin
            regs[w_wa_reg] <= w_result;
        end
    end

    assign wb_vld  = w_writes;
    assign wb_wa   = w_wa_reg;
    assign wb_data = w_result;
    assign busy    = (fifo_count != '0) || x_vld_reg || w_vld_reg;

endmodule

// File: tb/tb_precompute_exe_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a sequential ISA model.
module tb_precompute_exe_pipe;
    import precompute_pkg::*;

    localparam int W    = 32;
    localparam int NR   = 32;
    localparam int FD   = 4;
    localparam int RA_W = $clog2(NR);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_vld;
    logic [3:0]      in_op;
    logic [RA_W-1:0] in_wa;
    logic [RA_W-1:0] in_ra0;
    logic [RA_W-1:0] in_ra1;
    logic [W-1:0]    in_imm;
    logic            in_rdy;
    logic            hold;
    logic            wb_vld;
    logic [RA_W-1:0] wb_wa;
    logic [W-1:0]    wb_data;
    logic            busy;

    precompute_exe_pipe #(.W(W), .N_REGS(NR), .FIFO_DEPTH(FD)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (in_vld),
        .in_op   (in_op),
        .in_wa   (in_wa),
        .in_ra0  (in_ra0),
        .in_ra1  (in_ra1),
        .in_imm  (in_imm),
        .in_rdy  (in_rdy),
        .hold    (hold),
        .wb_vld  (wb_vld),
        .wb_wa   (wb_wa),
        .wb_data (wb_data),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RA_W-1:0] wa;
        logic [W-1:0]    d;
    } wb_t;

    int          checks = 0;
    int          errors = 0;
    int          wb_cnt = 0;
    logic [W-1:0] mreg [NR];
    wb_t         exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Architectural model: ops retire in acceptance order, each seeing all earlier results.
    task automatic model_accept(input logic [3:0] op, input logic [RA_W-1:0] wa, ra0, ra1,
                                input logic [W-1:0] imm);
        logic [W-1:0] a, b, r;
        wb_t e;
        a = mreg[ra0];
        b = mreg[ra1];
        case (op)
            4'h1:    r = a & b;
            4'h2:    r = ~a;
            4'h3:    r = a | b;
            4'h4:    r = a ^ b;
            4'h5:    r = a + b;
            4'h6:    r = a - b;
            4'h7:    r = a;
            4'h8:    r = b;
            4'h9:    r = imm;
            default: r = '0;
        endcase
        if (op >= 4'h1 && op <= 4'h9) begin
            mreg[wa] = r;
            e.wa = wa;
            e.d  = r;
            exp_q.push_back(e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mreg[i] = '0;
        exp_q.delete();
    endtask

    // One clock: note acceptance before the edge, then check writeback just after it.
    task automatic tick();
        bit   acc, was_rst;
        logic [3:0] op;
        logic [RA_W-1:0] wa, ra0, ra1;
        logic [W-1:0] imm;
        wb_t  e;
        acc = in_vld && in_rdy && !rst;
        was_rst = rst;
        op = in_op; wa = in_wa; ra0 = in_ra0; ra1 = in_ra1; imm = in_imm;
        @(posedge clk);
        #1;
        if (was_rst) begin
            model_reset();
            chk("wb_vld_in_reset", wb_vld, 0);
        end else begin
            if (wb_vld) begin
                wb_cnt++;
                $display("wb: r%0d = %08h", wb_wa, wb_data);
                chk("wb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("wb_wa", wb_wa, e.wa);
                    chk("wb_data", wb_data, e.d);
                end
            end
            if (acc) model_accept(op, wa, ra0, ra1, imm);
        end
    endtask

    task automatic send(input logic [3:0] op, input int wa, ra0, ra1, input logic [W-1:0] imm);
        in_vld = 1'b1;
        in_op  = op;
        in_wa  = RA_W'(wa);
        in_ra0 = RA_W'(ra0);
        in_ra1 = RA_W'(ra1);
        in_imm = imm;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int c0;
        rst = 1'b1; in_vld = 1'b1; in_op = 4'h9; in_wa = '0; in_ra0 = '0; in_ra1 = '0;
        in_imm = 32'hDEAD_BEEF; hold = 1'b0;
        model_reset();

        // 1: reset held two cycles with in_vld high
        tick();
        tick();
        rst = 1'b0; in_vld = 1'b0;
        chk("rst_wb_vld", wb_vld, 0);
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wb_wa", wb_wa, 0);
        chk("rst_wb_data", wb_data, 0);
        idle(2);
        chk("rst_still_idle", busy, 0);

        // 2: back-to-back dependent ops, fixed latency
        send(OP_MOVI, 1, 0, 0, 32'd5);
        send(OP_MOVI, 2, 0, 0, 32'd7);
        send(OP_ADD, 3, 1, 2, 32'd0);
        chk("t2_r1_vld", wb_vld, 1);
        chk("t2_r1_wa", wb_wa, 1);
        chk("t2_r1_data", wb_data, 5);
        tick();
        chk("t2_r2_wa", wb_wa, 2);
        chk("t2_r2_data", wb_data, 7);
        tick();
        chk("t2_r3_vld", wb_vld, 1);
        chk("t2_r3_wa", wb_wa, 3);
        chk("t2_r3_data", wb_data, 12);
        idle(3);

        // 3: wraparound subtraction and doubling
        send(OP_MOVI, 4, 0, 0, 32'd0);
        send(OP_SUB, 5, 4, 1, 32'd0);
        send(OP_ADD, 6, 5, 5, 32'd0);
        tick();
        chk("t3_r5_wa", wb_wa, 5);
        chk("t3_r5_data", wb_data, 32'hFFFF_FFFB);
        tick();
        chk("t3_r6_wa", wb_wa, 6);
        chk("t3_r6_data", wb_data, 32'hFFFF_FFF6);
        idle(3);

        // 4: hold fills the FIFO, release drains at one op per cycle
        hold = 1'b1;
        for (int i = 0; i < FD; i++) send(OP_MOVI, 10 + i, 0, 0, $urandom);
        chk("t4_full_rdy", in_rdy, 0);
        chk("t4_no_wb", wb_vld, 0);
        chk("t4_busy", busy, 1);
        send(OP_MOVI, 20, 0, 0, 32'h1234);
        chk("t4_full_rdy2", in_rdy, 0);
        chk("t4_no_wb2", wb_vld, 0);
        hold = 1'b0;
        tick();
        chk("t4_rdy_after_pop", in_rdy, 1);
        for (int i = 0; i < FD; i++) begin
            tick();
            chk("t4_wb_vld", wb_vld, 1);
            chk("t4_wb_wa", wb_wa, 10 + i);
        end
        tick();
        chk("t4_wb_done", wb_vld, 0);
        idle(2);

        // 5: NOP / undefined opcodes produce bubbles only
        c0 = wb_cnt;
        send(OP_NOP, 7, 1, 2, 32'd0);
        send(4'hF, 7, 1, 2, 32'd0);
        send(OP_MOVI, 7, 0, 0, 32'd9);
        send(4'hA, 7, 1, 2, 32'd0);
        send(OP_NOP, 7, 0, 0, 32'd0);
        idle(5);
        chk("t5_one_wb", wb_cnt - c0, 1);
        send(OP_MOV0, 9, 7, 0, 32'd0);
        idle(2);
        chk("t5_r7_kept", wb_data, 9);

        // 6: reset with three ops in flight discards them
        send(OP_MOVI, 11, 0, 0, 32'h11);
        send(OP_MOVI, 12, 0, 0, 32'h22);
        send(OP_MOVI, 13, 0, 0, 32'h33);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        c0 = wb_cnt;
        idle(5);
        chk("t6_no_wb", wb_cnt - c0, 0);
        chk("t6_idle", busy, 0);
        send(OP_MOV0, 8, 1, 0, 32'd0);
        for (int i = 0; i < 10 && !wb_vld; i++) tick();
        chk("t6_mov0_vld", wb_vld, 1);
        chk("t6_mov0_wa", wb_wa, 8);
        chk("t6_mov0_data", wb_data, 0);
        idle(3);

        // Random traffic with random hold, dense register reuse
        for (int i = 0; i < 400; i++) begin
            hold   = ($urandom_range(0, 3) == 0);
            in_vld = $urandom_range(0, 1) == 1;
            in_op  = 4'($urandom_range(0, 15));
            in_wa  = RA_W'($urandom_range(0, 7));
            in_ra0 = RA_W'($urandom_range(0, 7));
            in_ra1 = RA_W'($urandom_range(0, 7));
            in_imm = $urandom;
            tick();
        end
        in_vld = 1'b0;
        hold = 1'b0;
        for (int i = 0; i < 50 && busy; i++) tick();
        idle(2);
        chk("drain_busy", busy, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
